// File: rtl/ccff_frame_loader_pkg.sv
// Shared types and helpers for the configuration-chain frame loader.
// Optional build macro: CCFF_PARITY_EN adds a trailing even-parity bit.
package fabric_cfg_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } ccff_state_e;

`ifdef CCFF_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Even parity: the frame is good when all bits XOR to zero.
  function automatic logic parity_ok(input logic [63:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/ccff_frame_loader_if.sv
// Serial config bus between a bitstream driver and a frame loader.
// slave: loader side (head/shift/load in; tail/sram/status out).
interface ccff_frame_loader_if #(
  parameter int NUM_SRAM = 2
);
  logic                  ccff_head;
  logic                  shift_en;
  logic                  load_en;
  logic                  ccff_tail;
  logic [0:NUM_SRAM-1]   sram;
  logic [0:NUM_SRAM-1]   sram_inv;
  logic                  cfg_valid;
  logic                  cfg_err;

  modport master (
    output ccff_head, shift_en, load_en,
    input  ccff_tail, sram, sram_inv,
    input  cfg_valid, cfg_err
  );

  modport slave (
    input  ccff_head, shift_en, load_en,
    output ccff_tail, sram, sram_inv,
    output cfg_valid, cfg_err
  );
endinterface

// File: rtl/ccff_shift_chain.sv
// LEN-bit serial shift chain; bit 0 takes i_head, o_tail is the MSB.
// Ports: i_clk, i_rst (async high), i_shift, i_head, o_tail, o_chain.
module ccff_shift_chain #(
  parameter int LEN = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_shift,
  input  logic           i_head,
  output logic           o_tail,
  output logic [LEN-1:0] o_chain
);

  logic [LEN-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= '0;
    end else if (i_shift) begin
      r_chain <= (r_chain << 1) | LEN'(i_head);
    end
  end

  assign o_chain = r_chain;
  assign o_tail  = r_chain[LEN-1];

endmodule

// File: rtl/ccff_frame_loader.sv
// Config-chain stage: shifts a frame in, commits it to mux select bits.
// Ports: prog_clk, prog_reset (async high), bus (slave). Macro: CCFF_PARITY_EN.
module ccff_frame_loader
  import fabric_cfg_pkg::*;
#(
  parameter  int NUM_SRAM = 2,
  localparam int CNT_W    = $clog2(NUM_SRAM + 2)
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  ccff_frame_loader_if.slave    bus
);

  localparam int FRAME_LEN = NUM_SRAM + PARITY_BITS;
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(FRAME_LEN);

  localparam logic [1:0] ST_EMPTY   = EMPTY;
  localparam logic [1:0] ST_FILLING = FILLING;
  localparam logic [1:0] ST_FULL    = FULL;

  logic [FRAME_LEN-1:0] w_chain;
  logic                 w_tail;
  logic                 w_par_ok;
  logic                 w_accept;
  logic                 w_reject;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [1:0]           w_state_nxt;
  logic [0:NUM_SRAM-1]  w_data;

  logic [CNT_W-1:0]     r_cnt;
  logic [1:0]           r_state;
  logic [0:NUM_SRAM-1]  r_sram;
  logic                 r_valid;
  logic                 r_err;

  ccff_shift_chain #(
    .LEN (FRAME_LEN)
  ) u_chain (
    .i_clk   (prog_clk),
    .i_rst   (prog_reset),
    .i_shift (bus.shift_en),
    .i_head  (bus.ccff_head),
    .o_tail  (w_tail),
    .o_chain (w_chain)
  );

`ifdef CCFF_PARITY_EN
  assign w_par_ok = parity_ok(64'(w_chain));
`else
  assign w_par_ok = 1'b1;
`endif

  // A shift in the same cycle always wins; the load is then refused.
  assign w_accept = bus.load_en & ~bus.shift_en
                  & (r_state == ST_FULL) & w_par_ok;
  assign w_reject = bus.load_en & ~w_accept;

  // Parity bit sits in chain[0]; data bits are above it.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_SRAM; i++) begin
      w_data[i] = w_chain[i + PARITY_BITS];
    end
  end

  // Count saturates so further shifting is pure pass-through.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_accept) begin
      w_cnt_nxt = '0;
    end else if (bus.shift_en && (r_cnt != LEN_C)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = ST_FILLING;
    unique case (1'b1)
      (w_cnt_nxt == '0):    w_state_nxt = ST_EMPTY;
      (w_cnt_nxt == LEN_C): w_state_nxt = ST_FULL;
      default:              w_state_nxt = ST_FILLING;
    endcase
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_cnt   <= '0;
      r_state <= ST_EMPTY;
      r_sram  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_sram  <= w_data;
        r_valid <= 1'b1;
        r_err   <= 1'b0;
      end else if (w_reject) begin
        r_err   <= 1'b1;
      end
    end
  end

  assign bus.ccff_tail = w_tail;
  assign bus.sram      = r_sram;
  assign bus.sram_inv  = ~r_sram;
  assign bus.cfg_valid = r_valid;
  assign bus.cfg_err   = r_err;

endmodule

// File: tb/tb_ccff_frame_loader.sv
// Directed bench for ccff_frame_loader with NUM_SRAM=2.
// Runs the parity sequence instead when CCFF_PARITY_EN is defined.
module tb_ccff_frame_loader;

  logic prog_clk;
  logic prog_reset;
  int   n_run;
  int   n_fail;

  ccff_frame_loader_if #(.NUM_SRAM(2)) bus ();

  ccff_frame_loader #(
    .NUM_SRAM (2)
  ) dut (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .bus        (bus)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive at negedge, let the rising edge take it, settle 1ns.
  task automatic step(input logic h, input logic s, input logic l);
    @(negedge prog_clk);
    bus.ccff_head = h;
    bus.shift_en  = s;
    bus.load_en   = l;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge prog_clk);
    prog_reset    = 1'b1;
    bus.ccff_head = 1'b0;
    bus.shift_en  = 1'b0;
    bus.load_en   = 1'b0;
    @(negedge prog_clk);
    prog_reset = 1'b0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    prog_reset    = 1'b1;
    bus.ccff_head = 1'b0;
    bus.shift_en  = 1'b0;
    bus.load_en   = 1'b0;
    repeat (2) @(posedge prog_clk);
    #1;
    chk("rst_sram",  8'(bus.sram),      8'h0);
    chk("rst_inv",   8'(bus.sram_inv),  8'h3);
    chk("rst_valid", 8'(bus.cfg_valid), 8'h0);
    chk("rst_err",   8'(bus.cfg_err),   8'h0);
    chk("rst_tail",  8'(bus.ccff_tail), 8'h0);
    @(negedge prog_clk);
    prog_reset = 1'b0;

`ifndef CCFF_PARITY_EN
    // Frame 1,0 -> chain[1]=1, chain[0]=0 -> sram[0:1]=01
    step(1'b1, 1'b1, 1'b0);
    chk("s1_tail", 8'(bus.ccff_tail), 8'h0);
    step(1'b0, 1'b1, 1'b0);
    chk("s2_tail", 8'(bus.ccff_tail), 8'h1);
    chk("s2_sram", 8'(bus.sram),      8'h0);
    step(1'b0, 1'b0, 1'b1);
    chk("ld_sram",  8'(bus.sram),      8'h1);
    chk("ld_inv",   8'(bus.sram_inv),  8'h2);
    chk("ld_valid", 8'(bus.cfg_valid), 8'h1);
    chk("ld_err",   8'(bus.cfg_err),   8'h0);
    // Load held a second cycle sees EMPTY
    step(1'b0, 1'b0, 1'b1);
    chk("hold_err",  8'(bus.cfg_err), 8'h1);
    chk("hold_sram", 8'(bus.sram),    8'h1);

    // Partial frame: one bit then load
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("part_err",  8'(bus.cfg_err), 8'h1);
    chk("part_sram", 8'(bus.sram),    8'h1);

    // Complete frame -> chain 1,0; then shift+load together
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("sl_err",  8'(bus.cfg_err),   8'h1);
    chk("sl_sram", 8'(bus.sram),      8'h1);
    chk("sl_tail", 8'(bus.ccff_tail), 8'h0);
    // Still FULL with chain 0,1 -> sram[0]=1, sram[1]=0
    step(1'b0, 1'b0, 1'b1);
    chk("sl_ld_sram", 8'(bus.sram),     8'h2);
    chk("sl_ld_inv",  8'(bus.sram_inv), 8'h1);
    chk("sl_ld_err",  8'(bus.cfg_err),  8'h0);

    // Stream 1,1,0,0: tail shows each bit two edges later
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("st2_tail", 8'(bus.ccff_tail), 8'h1);
    chk("st2_sram", 8'(bus.sram),      8'h2);
    step(1'b0, 1'b1, 1'b0);
    chk("st3_tail", 8'(bus.ccff_tail), 8'h1);
    chk("st3_sram", 8'(bus.sram),      8'h2);
    step(1'b0, 1'b1, 1'b0);
    chk("st4_tail", 8'(bus.ccff_tail), 8'h0);
    chk("st4_sram", 8'(bus.sram),      8'h2);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("st_ld_sram", 8'(bus.sram),     8'h0);
    chk("st_ld_inv",  8'(bus.sram_inv), 8'h3);

    // Async reset mid-shift discards the partial frame
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("pre_rst_tail", 8'(bus.ccff_tail), 8'h1);
    #2;
    prog_reset = 1'b1;
    #1;
    chk("arst_tail",  8'(bus.ccff_tail), 8'h0);
    chk("arst_valid", 8'(bus.cfg_valid), 8'h0);
    chk("arst_inv",   8'(bus.sram_inv),  8'h3);
    @(negedge prog_clk);
    prog_reset = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    chk("post_rst_err",  8'(bus.cfg_err), 8'h1);
    chk("post_rst_sram", 8'(bus.sram),    8'h0);
`else
    // Frame 1,0,0 has odd parity -> rejected
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("p_bad_tail", 8'(bus.ccff_tail), 8'h1);
    step(1'b0, 1'b0, 1'b1);
    chk("p_bad_err",   8'(bus.cfg_err),   8'h1);
    chk("p_bad_valid", 8'(bus.cfg_valid), 8'h0);
    chk("p_bad_sram",  8'(bus.sram),      8'h0);
    do_reset();
    // Data 1,1 plus parity 0 -> accepted
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("p_ok_tail", 8'(bus.ccff_tail), 8'h1);
    step(1'b0, 1'b0, 1'b1);
    chk("p_ok_sram",  8'(bus.sram),      8'h3);
    chk("p_ok_inv",   8'(bus.sram_inv),  8'h0);
    chk("p_ok_valid", 8'(bus.cfg_valid), 8'h1);
    chk("p_ok_err",   8'(bus.cfg_err),   8'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
